// File: rtl/neuron_feeder_if.sv
`timescale 1ns/1ps
// Memory, neuron and result-buffer signals between neuron_feeder (master) and the
// surrounding memories / serial neuron / result buffer (slave).
interface neuron_feeder_if #(
  parameter int IN_WIDTH = 16,
  parameter int PIX_AW   = 10,
  parameter int W_AW     = 13,
  parameter int N_AW     = 4
);
  logic                mem_rd;
  logic [PIX_AW-1:0]   pix_addr;
  logic [IN_WIDTH-1:0] pix_data;
  logic [W_AW-1:0]     w_addr;
  logic [IN_WIDTH-1:0] w_data;
  logic [N_AW-1:0]     b_addr;
  logic [IN_WIDTH-1:0] b_data;
  logic [IN_WIDTH-1:0] data_in;
  logic [IN_WIDTH-1:0] weight_in;
  logic [IN_WIDTH-1:0] bias_in;
  logic                input_valid;
  logic                neuron_clr;
  logic                neuron_valid;
  logic [15:0]         neuron_data;
  logic                res_we;
  logic [N_AW-1:0]     res_addr;
  logic [15:0]         res_data;

  modport master (
    output mem_rd, pix_addr, w_addr, b_addr, data_in, weight_in, bias_in,
           input_valid, neuron_clr, res_we, res_addr, res_data,
    input  pix_data, w_data, b_data, neuron_valid, neuron_data
  );

  modport slave (
    input  mem_rd, pix_addr, w_addr, b_addr, data_in, weight_in, bias_in,
           input_valid, neuron_clr, res_we, res_addr, res_data,
    output pix_data, w_data, b_data, neuron_valid, neuron_data
  );
endinterface

// File: rtl/neuron_feeder.sv
`timescale 1ns/1ps
// Sequencer for the shared serial neuron: streams operand triples per neuron, collects
// each result into the result buffer, and recovers from abort or a silent neuron.
module neuron_feeder #(
  parameter int IN_WIDTH    = 16,
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int PIX_AW      = 10,
  parameter int W_AW        = 13,
  parameter int N_AW        = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic error,
  neuron_feeder_if.master bus
);
  localparam int TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PIX_AW-1:0] I_LAST = PIX_AW'(NUM_INPUTS - 1);
  localparam logic [N_AW-1:0]   N_LAST = N_AW'(NUM_NEURONS - 1);
  localparam logic [W_AW-1:0]   W_STEP = W_AW'(NUM_INPUTS);
  localparam logic [TC_W-1:0]   T_LAST = TC_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, WRITE} state_t;

  state_t            state, state_nxt;
  logic [PIX_AW-1:0] i_q, i_nxt;
  logic [N_AW-1:0]   n_q, n_nxt;
  logic [W_AW-1:0]   base_q, base_nxt;
  logic [TC_W-1:0]   tcnt_q, tcnt_nxt;
  logic              err_nxt, clr_nxt, cap;
  logic              halt, rd, we;
  logic              vld_p1, clr_p1;
  logic [15:0]       res_p1;
  logic [IN_WIDTH-1:0] op_pix, op_w, op_b;

  assign halt = abort && (state != IDLE);
  assign rd   = (state == STREAM);
  assign we   = (state == WRITE) && !abort;

  always_comb begin
    state_nxt = state;
    i_nxt     = i_q;
    n_nxt     = n_q;
    base_nxt  = base_q;
    tcnt_nxt  = '0;
    err_nxt   = error;
    clr_nxt   = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          err_nxt   = 1'b0;
          i_nxt     = '0;
          n_nxt     = '0;
          base_nxt  = '0;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (i_q == I_LAST) begin
          i_nxt     = '0;
          state_nxt = WAIT;
        end else begin
          i_nxt = i_q + 1'b1;
        end
      end
      WAIT: begin
        if (bus.neuron_valid) begin
          cap       = 1'b1;
          state_nxt = WRITE;
        end else if (tcnt_q == T_LAST) begin
          err_nxt   = 1'b1;
          clr_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tcnt_nxt = tcnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (n_q == N_LAST) begin
          state_nxt = IDLE;
        end else begin
          n_nxt     = n_q + 1'b1;
          base_nxt  = base_q + W_STEP;
          state_nxt = STREAM;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every transition and flushes the neuron's partial sum.
    if (halt) begin
      state_nxt = IDLE;
      i_nxt     = '0;
      tcnt_nxt  = '0;
      err_nxt   = error;
      clr_nxt   = 1'b1;
      cap       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      i_q    <= '0;
      n_q    <= '0;
      base_q <= '0;
      tcnt_q <= '0;
      error  <= 1'b0;
      vld_p1 <= 1'b0;
      clr_p1 <= 1'b0;
      res_p1 <= '0;
    end else begin
      state  <= state_nxt;
      i_q    <= i_nxt;
      n_q    <= n_nxt;
      base_q <= base_nxt;
      tcnt_q <= tcnt_nxt;
      error  <= err_nxt;
      // Stage p1: read data returns, so the operand-valid lags the read by one cycle.
      vld_p1 <= rd && !halt;
      clr_p1 <= clr_nxt;
      if (cap) res_p1 <= bus.neuron_data;
    end
  end

  assign op_pix = bus.pix_data;
  assign op_w   = bus.w_data;
  assign op_b   = bus.b_data;

  assign busy          = (state != IDLE);
  assign done          = we && (n_q == N_LAST);
  assign bus.mem_rd    = rd;
  assign bus.pix_addr  = i_q;
  assign bus.w_addr    = base_q + W_AW'(i_q);
  assign bus.b_addr    = n_q;
  assign bus.data_in   = op_pix;
  assign bus.weight_in = op_w;
  assign bus.bias_in   = op_b;
  assign bus.input_valid = vld_p1;
  assign bus.neuron_clr  = clr_p1;
  assign bus.res_we    = we;
  assign bus.res_addr  = n_q;
  assign bus.res_data  = res_p1;
endmodule

// File: tb/tb_neuron_feeder.sv
`timescale 1ns/1ps
// Bench for neuron_feeder in a 4-input, 3-neuron configuration with memory and neuron
// stubs; expectations come from per-neuron sequence/cycle formulas.
module tb_neuron_feeder;
  localparam int IW = 16, NI = 4, NN = 3, PAW = 10, WAW = 13, NAW = 4, TO = 16;
  localparam int PER = NI + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, error;

  neuron_feeder_if #(.IN_WIDTH(IW), .PIX_AW(PAW), .W_AW(WAW), .N_AW(NAW)) bif ();

  neuron_feeder #(
    .IN_WIDTH(IW), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .PIX_AW(PAW),
    .W_AW(WAW), .N_AW(NAW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error), .bus(bif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] pix_mem [0:1023];
  logic [15:0] w_mem   [0:8191];
  logic [15:0] b_mem   [0:15];
  logic [15:0] nv_res  [0:15];

  always @(posedge clk) begin
    if (bif.mem_rd) begin
      bif.pix_data <= pix_mem[bif.pix_addr];
      bif.w_data   <= w_mem[bif.w_addr];
      bif.b_data   <= b_mem[bif.b_addr];
    end
  end

  // Neuron stub: after NI operands it answers one cycle later with nv_res[burst].
  bit nv_silent = 1'b0;
  bit nv_rewind = 1'b0;
  bit spur = 1'b0;
  logic nv_q;
  logic [15:0] nv_d;
  int nv_cnt, nv_idx;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      nv_q <= 1'b0; nv_d <= '0; nv_cnt <= 0; nv_idx <= 0;
    end else begin
      nv_q <= 1'b0;
      if (nv_rewind) nv_idx <= 0;
      if (bif.neuron_clr) nv_cnt <= 0;
      else if (bif.input_valid) begin
        if (nv_cnt == NI - 1) begin
          nv_cnt <= 0;
          nv_idx <= nv_idx + 1;
          if (!nv_silent) begin
            nv_q <= 1'b1;
            nv_d <= nv_res[nv_idx % 16];
          end
        end else nv_cnt <= nv_cnt + 1;
      end
    end
  end

  assign bif.neuron_valid = nv_q | spur;
  assign bif.neuron_data  = spur ? 16'hDEAD : nv_d;

  logic [47:0] iv_q [$];
  int          iv_c [$];
  logic [26:0] rd_q [$];
  int          rd_c [$];
  logic [19:0] wr_q [$];
  int          wr_c [$];
  int done_n, done_c, idle_c, clr_n, clr_c, err_first;
  logic err1, err_idle;

  task automatic load_mem(input bit rnd);
    for (int j = 0; j < NI; j++) pix_mem[j] = rnd ? 16'($urandom) : 16'(j + 1);
    for (int e = 0; e < NI * NN; e++) w_mem[e] = rnd ? 16'($urandom) : 16'(e + 5);
    for (int n = 0; n < NN; n++) begin
      b_mem[n]  = rnd ? 16'($urandom) : 16'(16'h0100 + n);
      nv_res[n] = rnd ? 16'($urandom) : 16'(16'h0010 + n);
    end
  endtask

  // Start a run and log every observable event by cycle (cycle 1 = first cycle after start is taken).
  task automatic capture(input int hold_until, input int spur_at, input int abort_at, input bit abort_start);
    iv_q.delete(); iv_c.delete(); rd_q.delete(); rd_c.delete(); wr_q.delete(); wr_c.delete();
    done_n = 0; done_c = -1; idle_c = -1; clr_n = 0; clr_c = -1; err_first = -1;
    err1 = 1'bx; err_idle = 1'bx;
    nv_rewind = 1'b1; start = 1'b1; abort = abort_start;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (bif.input_valid) begin iv_q.push_back({bif.data_in, bif.weight_in, bif.bias_in}); iv_c.push_back(k); end
      if (bif.mem_rd) begin rd_q.push_back({bif.pix_addr, bif.w_addr, bif.b_addr}); rd_c.push_back(k); end
      if (bif.res_we) begin wr_q.push_back({bif.res_addr, bif.res_data}); wr_c.push_back(k); end
      if (done) begin done_n++; done_c = k; end
      if (bif.neuron_clr) begin clr_n++; clr_c = k; end
      if (k == 1) err1 = error;
      if (error === 1'b1 && err_first < 0) err_first = k;
      if (!busy && idle_c < 0) begin idle_c = k; err_idle = error; end
      nv_rewind = 1'b0;
      if (k >= hold_until) start = 1'b0;
      abort = (k == abort_at);
      spur  = (k == spur_at);
      if (idle_c >= 0 && k >= idle_c + 2) break;
    end
    start = 1'b0; abort = 1'b0; spur = 1'b0;
  endtask

  task automatic test_reset();
    logic [53:0] obs;
    #1 rst = 1'b0;
    #1;
    obs = {busy, done, error, bif.mem_rd, bif.input_valid, bif.neuron_clr, bif.res_we,
           bif.pix_addr, bif.w_addr, bif.b_addr, bif.res_addr, bif.res_data};
    n_vec++;
    if (obs !== '0) begin n_bad++; $display("FAIL reset_state: outputs %h, want 0", obs); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: busy %b, want 0", busy); end
  endtask

  task automatic test_run(input string tag, input bit rnd, input int hold_until, input int spur_at, input bit abort_start);
    int e;
    logic [47:0] texp;
    logic [26:0] rexp;
    logic [19:0] wexp;
    load_mem(rnd);
    capture(hold_until, spur_at, 0, abort_start);
    n_vec++;
    if (iv_q.size() != NN * NI || rd_q.size() != NN * NI || wr_q.size() != NN) begin
      n_bad++;
      $display("FAIL %s counts: iv %0d rd %0d wr %0d, want %0d %0d %0d", tag, iv_q.size(), rd_q.size(), wr_q.size(), NN * NI, NN * NI, NN);
    end
    for (int n = 0; n < NN; n++) begin
      for (int j = 0; j < NI; j++) begin
        e = n * NI + j;
        texp = {pix_mem[j], w_mem[e], b_mem[n]};
        rexp = {PAW'(j), WAW'(e), NAW'(n)};
        if (e < iv_q.size()) begin
          n_vec++;
          if (iv_q[e] !== texp || iv_c[e] != n * PER + 2 + j) begin
            n_bad++;
            $display("FAIL %s operand[%0d]: got %h @%0d, want %h @%0d", tag, e, iv_q[e], iv_c[e], texp, n * PER + 2 + j);
          end
        end
        if (e < rd_q.size()) begin
          n_vec++;
          if (rd_q[e] !== rexp || rd_c[e] != n * PER + 1 + j) begin
            n_bad++;
            $display("FAIL %s read[%0d]: got %h @%0d, want %h @%0d", tag, e, rd_q[e], rd_c[e], rexp, n * PER + 1 + j);
          end
        end
      end
      wexp = {NAW'(n), nv_res[n]};
      if (n < wr_q.size()) begin
        n_vec++;
        if (wr_q[n] !== wexp || wr_c[n] != (n + 1) * PER) begin
          n_bad++;
          $display("FAIL %s write[%0d]: got %h @%0d, want %h @%0d", tag, n, wr_q[n], wr_c[n], wexp, (n + 1) * PER);
        end
      end
    end
    n_vec++;
    if (done_n != 1 || done_c != NN * PER || idle_c != NN * PER + 1) begin
      n_bad++;
      $display("FAIL %s done: %0d pulses @%0d idle @%0d, want 1 @%0d idle @%0d", tag, done_n, done_c, idle_c, NN * PER, NN * PER + 1);
    end
    n_vec++;
    if (clr_n != 0 || err1 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s clr_err: clr %0d error %b, want 0 0", tag, clr_n, err1);
    end
  endtask

  task automatic test_timeout();
    load_mem(1'b1);
    nv_silent = 1'b1;
    capture(1, 0, 0, 1'b0);
    nv_silent = 1'b0;
    n_vec++;
    if (iv_q.size() != NI || wr_q.size() != 0 || done_n != 0) begin
      n_bad++;
      $display("FAIL timeout counts: iv %0d wr %0d done %0d, want %0d 0 0", iv_q.size(), wr_q.size(), done_n, NI);
    end
    n_vec++;
    if (idle_c != NI + TO + 1 || clr_n != 1 || clr_c != NI + TO + 1) begin
      n_bad++;
      $display("FAIL timeout timing: idle @%0d clr %0d @%0d, want idle @%0d clr 1 @%0d", idle_c, clr_n, clr_c, NI + TO + 1, NI + TO + 1);
    end
    n_vec++;
    if (err_first != NI + TO + 1 || err_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout error: first @%0d at_idle %b, want @%0d 1", err_first, err_idle, NI + TO + 1);
    end
    // Abort while idle must leave the sticky error and state alone.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || error !== 1'b1 || bif.neuron_clr !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_abort: busy %b error %b clr %b, want 0 1 0", busy, error, bif.neuron_clr);
    end
  endtask

  task automatic test_abort();
    int a, cnt;
    logic [47:0] texp;
    a = PER + 3;
    load_mem(1'b0);
    capture(1, 0, a, 1'b0);
    cnt = 0;
    for (int n = 0; n < NN; n++) begin
      for (int j = 0; j < NI; j++) begin
        if (n * PER + 2 + j <= a) begin
          texp = {pix_mem[j], w_mem[n * NI + j], b_mem[n]};
          if (cnt < iv_q.size()) begin
            n_vec++;
            if (iv_q[cnt] !== texp || iv_c[cnt] != n * PER + 2 + j) begin
              n_bad++;
              $display("FAIL abort operand[%0d]: got %h @%0d, want %h @%0d", cnt, iv_q[cnt], iv_c[cnt], texp, n * PER + 2 + j);
            end
          end
          cnt++;
        end
      end
    end
    n_vec++;
    if (iv_q.size() != cnt || rd_q.size() != NI + 3) begin
      n_bad++;
      $display("FAIL abort counts: iv %0d rd %0d, want %0d %0d", iv_q.size(), rd_q.size(), cnt, NI + 3);
    end
    n_vec++;
    if (wr_q.size() != 1 || done_n != 0) begin
      n_bad++;
      $display("FAIL abort writes: wr %0d done %0d, want 1 0", wr_q.size(), done_n);
    end
    n_vec++;
    if (idle_c != a + 1 || clr_n != 1 || clr_c != a + 1 || err_idle !== 1'b0) begin
      n_bad++;
      $display("FAIL abort recovery: idle @%0d clr %0d @%0d err %b, want @%0d 1 @%0d 0", idle_c, clr_n, clr_c, err_idle, a + 1, a + 1);
    end
  endtask

  task automatic test_reset_midstream();
    logic [53:0] obs;
    load_mem(1'b0);
    nv_rewind = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; nv_rewind = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bif.mem_rd !== 1'b1 || bif.input_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midstream_pre: mem_rd %b input_valid %b, want 1 1", bif.mem_rd, bif.input_valid);
    end
    #2 rst = 1'b0;
    #0.5;
    obs = {busy, done, error, bif.mem_rd, bif.input_valid, bif.neuron_clr, bif.res_we,
           bif.pix_addr, bif.w_addr, bif.b_addr, bif.res_addr, bif.res_data};
    n_vec++;
    if (obs !== '0) begin n_bad++; $display("FAIL async_reset: outputs %h, want 0", obs); end
    #0.5 rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || bif.mem_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: busy %b mem_rd %b, want 0 0", busy, bif.mem_rd);
    end
    test_run("replay", 1'b0, 1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_run("nominal", 1'b0, 1, 0, 1'b0);
    test_run("random", 1'b1, 1, 0, 1'b1);
    test_run("hold_spur", 1'b1, NN * PER - 3, 2, 1'b0);
    test_timeout();
    test_run("after_timeout", 1'b0, 1, 0, 1'b0);
    test_abort();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
- Upstream sequencer for the serial `neuron` MAC stage.
- On `start`, it runs each of NUM_NEURONS neurons in turn through the single shared neuron:
  - reads pixel, weight and bias memories (synchronous, 1-cycle read latency);
  - streams exactly NUM_INPUTS operand triples with `input_valid`;
  - waits for the neuron's `out_valid` and writes the 16-bit result into a result buffer.
- Also handles abort and neuron-timeout recovery.

Parameters:
- IN_WIDTH, 16, operand width of pixel/weight/bias words.
- NUM_INPUTS, 784, operands per neuron.
- NUM_NEURONS, 10, neurons evaluated per `start`.
- PIX_AW, 10, pixel address width (>= clog2(NUM_INPUTS)).
- W_AW, 13, weight address width (>= clog2(NUM_INPUTS*NUM_NEURONS)).
- N_AW, 4, neuron index width (>= clog2(NUM_NEURONS)).
- TIMEOUT, 16, max cycles in WAIT before error.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a run; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last result is written.
- error  out  1  sticky timeout flag; cleared by the next accepted `start`.
- mem_rd  out  1  read enable for all three memories.
- pix_addr  out  PIX_AW  pixel memory address.
- pix_data  in  IN_WIDTH  pixel read data, valid one cycle after `mem_rd`.
- w_addr  out  W_AW  weight memory address.
- w_data  in  IN_WIDTH  weight read data, valid one cycle after `mem_rd`.
- b_addr  out  N_AW  bias memory address.
- b_data  in  IN_WIDTH  bias read data, valid one cycle after `mem_rd`.
- data_in  out  IN_WIDTH  to neuron; combinational copy of `pix_data`.
- weight_in  out  IN_WIDTH  to neuron; combinational copy of `w_data`.
- bias_in  out  IN_WIDTH  to neuron; combinational copy of `b_data`.
- input_valid  out  1  to neuron; operand triple valid.
- neuron_clr  out  1  one-cycle pulse driving the neuron's synchronous clear.
- neuron_valid  in  1  neuron `out_valid`.
- neuron_data  in  16  neuron `data_out`.
- res_we  out  1  result buffer write enable.
- res_addr  out  N_AW  result index (= neuron number).
- res_data  out  16  registered result.

Behaviour:
- Reset (`rst`=0, async): state=IDLE, all counters 0.
  - `busy`, `done`, `error`, `mem_rd`, `input_valid`, `neuron_clr`, `res_we` = 0.
  - All address outputs and `res_data` = 0.
- States: IDLE, STREAM, WAIT, WRITE.
- IDLE:
  - `start`=1 → clear `error`, n=0, i=0, base=0, go STREAM.
  - `start` is ignored in every other state.
- STREAM: each cycle `mem_rd`=1, `pix_addr`=i, `w_addr`=base+i, `b_addr`=n.
  - Weight addressing uses a running base register, no multiplier.
  - On i==NUM_INPUTS-1: i←0, go WAIT.
  - Otherwise i←i+1.
  - STREAM lasts exactly NUM_INPUTS cycles.
- `input_valid`: `mem_rd` delayed one cycle (registered).
  - Exactly NUM_INPUTS consecutive `input_valid` cycles per neuron.
  - No gaps.
  - The last one falls in the first WAIT cycle.
- WAIT:
  - Timeout counter starts at 0 on entry and increments each cycle.
  - `neuron_valid`=1 → capture `neuron_data` into `res_data`, go WRITE.
  - Counter reaches TIMEOUT without `neuron_valid` → `error`←1, `neuron_clr` pulse, go IDLE, no `done`.
  - With the neuron's 1-cycle latency, `neuron_valid` arrives on the 2nd WAIT cycle.
- WRITE (1 cycle):
  - `res_we`=1, `res_addr`=n.
  - If n==NUM_NEURONS-1: `done`=1 in this same cycle, then IDLE.
  - Otherwise n←n+1, base←base+NUM_INPUTS, go STREAM.
- Per-neuron cost: NUM_INPUTS+3 cycles (STREAM + 2 WAIT + WRITE).
- `neuron_valid` outside WAIT: ignored; no write, no state change.
- `abort`:
  - Highest priority over all transitions except reset.
  - From any non-IDLE state: next state IDLE.
  - `mem_rd` and `input_valid` forced 0 from the next cycle.
  - One `neuron_clr` pulse to flush the partial accumulator.
  - No `res_we`, no `done`; `error` unchanged.
  - `abort` in IDLE: no effect.
- `abort` and `start` together in IDLE: `start` wins.
- The in-flight `input_valid` from the last STREAM cycle is suppressed if `abort` occurs in that cycle.
- `busy`=1 exactly when state≠IDLE.
- Result buffer content is never modified except via `res_we`.

Test Plan:
- NUM_INPUTS=4, NUM_NEURONS=3; `start` pulse; model neuron with 1-cycle latency returning 16'h0010+n.
  - Expect 12 `input_valid` cycles (3 bursts of 4).
  - `w_addr` sequence 0..11; `b_addr` 0,1,2.
  - `res_we` at `res_addr` 0,1,2 with data 0010/0011/0012.
  - `done` on cycle 3·7=21 after `start`; `busy` low next cycle.
- Pixel memory holds 1..4, weight memory 5..16.
  - `data_in`/`weight_in` pairs must match (1,5),(2,6),(3,7),(4,8),(1,9),(2,10)… aligned with `input_valid`.
- Neuron model never asserts valid.
  - `error`=1 and `neuron_clr` pulse TIMEOUT cycles into WAIT; back to IDLE; no `done`, no `res_we`.
  - Next `start` clears `error`.
- `abort` on the 3rd STREAM cycle of neuron 1.
  - `input_valid` low from the next cycle; one `neuron_clr` pulse; IDLE; `res_we` count stays 1.
- `start` held high during a run → no restart or counter reset.
  - Spurious `neuron_valid` during STREAM → no write.
- Async reset (`rst`=0 for 1 ns mid-STREAM, between clock edges).
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, IDLE; a fresh `start` reproduces scenario 1 exactly.
